io_seq_monitor: RTL

- Parametrised hardware sequence checker for the natalius SoC user area.
- Watches a WIDTH-bit IO bus, typically mprj_io[7:0], for a programmed ordered list of expected values.
- Adds a per-step timeout, glitch filtering, a strict mode that flags unexpected intermediate values, and pass/fail status with a fail code.
- Sits beside the GPIO outputs for on-chip self-test; its status bits are readable over Wishbone glue.

---
 rtl/io_seq_monitor.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/io_seq_monitor.sv
// Sequence checker: watches a glitch-filtered IO bus for a programmed ordered list of values.
// Latency io_in->filt_value 2+STABLE_CYC cycles, ->step_idx/pass/fail 3+STABLE_CYC; no backpressure.
module io_seq_monitor #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int TIMEOUT_W  = 24,
  parameter int STABLE_CYC = 2,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [WIDTH-1:0]     io_in,
  input  logic                 prog_we,
  input  logic [AW-1:0]        prog_addr,
  input  logic [WIDTH-1:0]     prog_data,
  input  logic [AW:0]          seq_len,
  input  logic [TIMEOUT_W-1:0] timeout_cyc,
  input  logic                 strict,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           fail_code,
  output logic [AW-1:0]        step_idx,
  output logic [WIDTH-1:0]     filt_value
);

  localparam int SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]     sync1, sync2, sync3;
  logic [SW-1:0]        stable_cnt, stable_nxt;
  logic                 new_vld;

  logic [WIDTH-1:0]     exp_mem [DEPTH];
  logic [WIDTH-1:0]     exp_cur;
  logic [WIDTH-1:0]     prev_value;
  logic [AW:0]          len_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic                 strict_q;
  logic [TIMEOUT_W-1:0] timer;

  logic cfg_bad, is_last, is_match, is_strict_err, is_timeout;
  logic do_clear, do_cfg_err, do_arm, do_match, do_pass, do_fail_strict, do_fail_tmo;

  // Count how long sync2 has held its value; a change restarts the count at 1.
  always_comb begin
    if (sync2 != sync3)
      stable_nxt = SW'(1);
    else if (stable_cnt == SW'(STABLE_CYC))
      stable_nxt = stable_cnt;
    else
      stable_nxt = stable_cnt + SW'(1);
  end

  // new_vld marks the single cycle where filt_value holds a freshly accepted value.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1      <= '0;
      sync2      <= '0;
      sync3      <= '0;
      stable_cnt <= '0;
      filt_value <= '0;
      new_vld    <= 1'b0;
    end else begin
      sync1      <= io_in;
      sync2      <= sync1;
      sync3      <= sync2;
      stable_cnt <= stable_nxt;
      new_vld    <= 1'b0;
      if (stable_nxt == SW'(STABLE_CYC) && sync2 != filt_value) begin
        filt_value <= sync2;
        new_vld    <= 1'b1;
      end
    end
  end

  // Expected-value store survives reset so a re-armed run can reuse it.
  always_ff @(posedge wb_clk_i) begin
    if (prog_we && !busy && int'(prog_addr) < DEPTH)
      exp_mem[prog_addr] <= prog_data;
  end

  assign exp_cur       = exp_mem[step_idx];
  assign cfg_bad       = (seq_len == '0) || (seq_len > (AW+1)'(DEPTH));
  assign is_last       = ({1'b0, step_idx} == len_q - (AW+1)'(1));
  assign is_match      = new_vld && (filt_value == exp_cur);
  assign is_strict_err = new_vld && !is_match && strict_q && (filt_value != prev_value);
  assign is_timeout    = (tmo_q != '0) && (timer == tmo_q - TIMEOUT_W'(1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start)
          state_nxt = cfg_bad ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (is_match) begin
          if (is_last)
            state_nxt = S_DONE;
        end else if (is_strict_err || is_timeout) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort)
      state_nxt = S_IDLE;
  end

  // A match outranks a timeout landing on the same cycle.
  always_comb begin
    busy           = (state == S_WAIT);
    do_clear       = 1'b0;
    do_cfg_err     = 1'b0;
    do_arm         = 1'b0;
    do_match       = 1'b0;
    do_pass        = 1'b0;
    do_fail_strict = 1'b0;
    do_fail_tmo    = 1'b0;
    if (abort) begin
      do_clear = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            do_cfg_err = cfg_bad;
            do_arm     = !cfg_bad;
          end
        end
        S_WAIT: begin
          if (is_match) begin
            do_match = 1'b1;
            do_pass  = is_last;
          end else if (is_strict_err) begin
            do_fail_strict = 1'b1;
          end else if (is_timeout) begin
            do_fail_tmo = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_code  <= 2'd0;
      step_idx   <= '0;
      timer      <= '0;
      prev_value <= '0;
      len_q      <= '0;
      tmo_q      <= '0;
      strict_q   <= 1'b0;
    end else if (do_clear) begin
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'd0;
      timer     <= '0;
    end else if (do_cfg_err) begin
      pass      <= 1'b0;
      fail      <= 1'b1;
      fail_code <= 2'd3;
    end else if (do_arm) begin
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_code  <= 2'd0;
      step_idx   <= '0;
      timer      <= '0;
      prev_value <= filt_value;
      len_q      <= seq_len;
      tmo_q      <= timeout_cyc;
      strict_q   <= strict;
    end else if (busy) begin
      if (do_match) begin
        prev_value <= filt_value;
        timer      <= '0;
        if (do_pass)
          pass <= 1'b1;
        else
          step_idx <= step_idx + AW'(1);
      end else if (do_fail_strict) begin
        fail      <= 1'b1;
        fail_code <= 2'd2;
      end else if (do_fail_tmo) begin
        fail      <= 1'b1;
        fail_code <= 2'd1;
      end else begin
        timer <= timer + TIMEOUT_W'(1);
      end
    end
  end

endmodule
